// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the shared-multiplier controller
package mul_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;
  localparam int NREQ = 2;
  localparam int W_DEF = 16;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant picker; pointer names the preferred client on a tie
module rr_arb2
  import mul_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic            ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            win_o
);
  assign win_o = req_i[1] & (~req_i[0] | ptr_i);
  assign gnt_o = (|req_i) ? (win_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: two-client sequencer and arbiter for a repeated-addition multiplier datapath
module mul_share_ctrl
  import mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    res0,
  output logic [W-1:0]    res1,
  output logic            busy,
  output logic            gnt_id,
  output logic [W-1:0]    dp_data,
  output logic            ldA,
  output logic            ldB,
  output logic            ldP,
  output logic            clrP,
  output logic            decB,
  input  logic            eqz,
  input  logic [W-1:0]    prod
);
  state_t          state_q, state_d;
  logic            ptr_q, ptr_d, gnt_id_q, gnt_id_d, win;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res0_q, res0_d, res1_q, res1_d;

  rr_arb2 u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .win_o(win)
  );

  assign busy   = state_q != IDLE;
  assign gnt_id = gnt_id_q;
  assign res0   = res0_q;
  assign res1   = res1_q;

  // next state, operand/result capture and Mealy strobe decode
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    a_d      = a_q;
    b_d      = b_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    done     = '0;
    dp_data  = '0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    ldP      = 1'b0;
    clrP     = 1'b0;
    decB     = 1'b0;
    case (state_q)
      IDLE: if (|gnt) begin
        a_d      = gnt[1] ? a1 : a0;
        b_d      = gnt[1] ? b1 : b0;
        gnt_id_d = win;
        ptr_d    = ~win;
        state_d  = LOAD_A;
      end
      LOAD_A: begin
        dp_data = a_q;
        ldA     = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        dp_data = b_q;
        ldB     = 1'b1;
        clrP    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        ldP  = ~eqz;
        decB = ~eqz;
        if (eqz) begin
          res0_d  = gnt_id_q ? res0_q : prod;
          res1_d  = gnt_id_q ? prod : res1_q;
          state_d = DONE;
        end
      end
      DONE: begin
        done[gnt_id_q] = 1'b1;
        if (!req[gnt_id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_id_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: scoreboard bench with a behavioural datapath model
module tb_mul_share_ctrl;
  typedef struct {int id; logic [15:0] res;} exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, gnt_id, busy, ldA, ldB, ldP, clrP, decB, eqz;
  logic [1:0]  req = 2'b00, done, done_prev = 2'b00;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, res0, res1, dp_data, prod;
  logic [15:0] am = '0, bm = '0, pm = '0;
  exp_t        sb[$];
  int          total = 0, bad = 0;

  mul_share_ctrl #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done(done), .res0(res0), .res1(res1), .busy(busy), .gnt_id(gnt_id),
    .dp_data(dp_data), .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB),
    .eqz(eqz), .prod(prod)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ldA) am <= dp_data;
    if (ldB) bm <= dp_data;
    if (decB) bm <= bm - 16'd1;
    if (clrP) pm <= '0;
    else if (ldP) pm <= pm + am;
  end
  assign eqz  = bm == 16'd0;
  assign prod = pm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i] && !done_prev[i]) begin
        if (sb.size() == 0) check("sb_underflow", 32'(i), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_id", 32'(i), 32'(e.id));
          check("sb_res", 32'(i == 1 ? res1 : res0), 32'(e.res));
        end
      end
    end
    done_prev = done;
  end

  task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
    if (id == 1) begin a1 = a; b1 = b; end
    else begin a0 = a; b0 = b; end
  endtask

  function automatic logic [15:0] mulw(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[15:0];
  endfunction

  task automatic push(input int id, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.id = id;
    e.res = mulw(a, b);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    while (!done[id] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 32'(done[id]), 1);
  endtask

  task automatic job(input int id, input logic [15:0] a, input logic [15:0] b, input bit drop);
    int cyc = 0, lp = 0;
    push(id, a, b);
    set_ops(id, a, b);
    req[id] = 1'b1;
    while (!done[id] && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ldP) lp++;
      if (drop && cyc == 3) begin
        req[id] = 1'b0;
        set_ops(id, 16'd100, 16'd100);
      end
    end
    check("latency", 32'(cyc), 32'(b) + 32'd4);
    check("ldp_cycles", 32'(lp), 32'(b));
    if (drop) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done[id]), 0);
      check("busy_after_drop", 32'(busy), 0);
    end else begin
      repeat (2) begin
        @(negedge clk);
        check("done_held", 32'(done[id]), 1);
      end
      req[id] = 1'b0;
      @(negedge clk);
      check("busy_after", 32'(busy), 0);
      check("done_clear", 32'(done[id]), 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_res0", 32'(res0), 0);
    check("rst_res1", 32'(res1), 0);
    check("rst_gnt", 32'(gnt_id), 0);
    check("rst_dp", 32'(dp_data), 0);
    check("rst_strobes", 32'({ldA, ldB, ldP, clrP, decB}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    job(0, 16'd10, 16'd6, 1'b0);
    check("res0_basic", 32'(res0), 60);
    job(1, 16'd25, 16'd0, 1'b0);
    check("res1_bzero", 32'(res1), 0);
    do_reset();
    set_ops(0, 16'd3, 16'd4);
    set_ops(1, 16'd5, 16'd2);
    push(0, 16'd3, 16'd4);
    push(1, 16'd5, 16'd2);
    req = 2'b11;
    @(negedge clk);
    check("tie_first", 32'(gnt_id), 0);
    wait_done(0);
    req[0] = 1'b0;
    @(negedge clk);
    check("idle_dwell", 32'(busy), 0);
    set_ops(0, 16'd7, 16'd1);
    push(0, 16'd7, 16'd1);
    req[0] = 1'b1;
    @(negedge clk);
    check("rr_second", 32'(gnt_id), 1);
    wait_done(1);
    req[1] = 1'b0;
    wait_done(0);
    req[0] = 1'b0;
    @(negedge clk);
    check("res_pair", 32'({res0, res1}), {16'd7, 16'd10});
    job(0, 16'd300, 16'd300, 1'b0);
    check("overflow", 32'(res0), 24464);
    set_ops(0, 16'd10, 16'd6);
    req[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_res0", 32'(res0), 0);
    check("mid_rst_out", 32'({dp_data, ldA, ldB, ldP, clrP, decB, gnt_id}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    job(0, 16'd10, 16'd6, 1'b0);
    job(1, 16'd9, 16'd5, 1'b1);
    check("latched_ops", 32'(res1), 45);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
